ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding stage of the RISC-V core, placed directly upstream of the ALU. It captures decoded instructions each cycle and selects the ALU operands. Operand sources are the register file, the PC, the immediate, or bypassed results from MEM and WB. It drives `Data_A`, `Data_B` and `ALUSel`, holds the EX/MEM result register that captures the ALU output, and detects load-use hazards and stalls decode.

---
 rtl/ex_operand_stage.sv | 155 +++++++++++++++
 tb/tb_ex_operand_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection
// and the EX/MEM result register feeding the memory stage.
module ex_operand_stage #(
  parameter logic [3:0] NOP_ALUSEL = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_a_sel,
  input  logic        id_b_sel,
  input  logic [3:0]  id_alu_sel,
  input  logic        id_reg_wen,
  input  logic        id_is_load,
  input  logic        flush,
  input  logic [31:0] alu_out,
  input  logic        wb_wen,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] Data_A,
  output logic [31:0] Data_B,
  output logic [3:0]  ALUSel,
  output logic [31:0] ex_rs2_fwd,
  output logic        ex_valid,
  output logic        ex_reg_wen,
  output logic        ex_is_load,
  output logic [4:0]  ex_rd,
  output logic [31:0] mem_result,
  output logic [4:0]  mem_rd,
  output logic        mem_valid,
  output logic        mem_reg_wen,
  output logic        mem_is_load,
  output logic        stall_id
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        a_sel;
    logic        b_sel;
    logic [3:0]  alu_sel;
    logic        reg_wen;
    logic        is_load;
  } ex_reg_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_wen;
    logic        is_load;
  } mem_reg_t;

  ex_reg_t  ex_q, ex_d, bubble;
  mem_reg_t mem_q, mem_d;

  logic        load_use;
  logic        mem_fwd_ok;
  logic        wb_fwd_ok;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;

  // The register file is not write-first, so a WB write to a source we are
  // reading right now must be folded in before the value is latched.
  always_comb begin
    bubble         = '0;
    bubble.alu_sel = NOP_ALUSEL;

    load_use = id_valid & ex_q.valid & ex_q.is_load & ex_q.reg_wen &
               (ex_q.rd != 5'd0) &
               ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
    stall_id = load_use & ~flush;

    ex_d = bubble;
    if (!flush && !load_use) begin
      ex_d.valid   = id_valid;
      ex_d.pc      = id_pc;
      ex_d.imm     = id_imm;
      ex_d.rs1     = id_rs1;
      ex_d.rs2     = id_rs2;
      ex_d.rd      = id_rd;
      ex_d.a_sel   = id_a_sel;
      ex_d.b_sel   = id_b_sel;
      ex_d.alu_sel = id_alu_sel;
      ex_d.reg_wen = id_reg_wen;
      ex_d.is_load = id_is_load;
      ex_d.rs1_val = (wb_wen && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
      ex_d.rs2_val = (wb_wen && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
    end

    mem_d.valid   = ex_q.valid;
    mem_d.result  = alu_out;
    mem_d.rd      = ex_q.rd;
    mem_d.reg_wen = ex_q.reg_wen;
    mem_d.is_load = ex_q.is_load;
  end

  // A load in MEM has no data yet; the load-use stall guarantees the
  // consumer instead sees it from WB one cycle later.
  always_comb begin
    mem_fwd_ok = mem_q.valid & mem_q.reg_wen & ~mem_q.is_load & (mem_q.rd != 5'd0);
    wb_fwd_ok  = wb_wen & (wb_rd != 5'd0);

    fwd_rs1 = ex_q.rs1_val;
    if (mem_fwd_ok && mem_q.rd == ex_q.rs1) begin
      fwd_rs1 = mem_q.result;
    end else if (wb_fwd_ok && wb_rd == ex_q.rs1) begin
      fwd_rs1 = wb_data;
    end

    fwd_rs2 = ex_q.rs2_val;
    if (mem_fwd_ok && mem_q.rd == ex_q.rs2) begin
      fwd_rs2 = mem_q.result;
    end else if (wb_fwd_ok && wb_rd == ex_q.rs2) begin
      fwd_rs2 = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= bubble;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

  assign Data_A      = ex_q.a_sel ? ex_q.pc : fwd_rs1;
  assign Data_B      = ex_q.b_sel ? ex_q.imm : fwd_rs2;
  assign ALUSel      = ex_q.alu_sel;
  assign ex_rs2_fwd  = fwd_rs2;
  assign ex_valid    = ex_q.valid;
  assign ex_reg_wen  = ex_q.reg_wen;
  assign ex_is_load  = ex_q.is_load;
  assign ex_rd       = ex_q.rd;
  assign mem_result  = mem_q.result;
  assign mem_rd      = mem_q.rd;
  assign mem_valid   = mem_q.valid;
  assign mem_reg_wen = mem_q.reg_wen;
  assign mem_is_load = mem_q.is_load;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed test-plan scenarios followed by a randomized phase, all checked
// against an instruction-level reference model of the EX and MEM stages.
module tb_ex_operand_stage;

  localparam logic [3:0] NOP = 4'b0000;

  logic        clk, rst;
  logic        id_valid;
  logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_a_sel, id_b_sel;
  logic [3:0]  id_alu_sel;
  logic        id_reg_wen, id_is_load, flush;
  logic [31:0] alu_out;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] Data_A, Data_B, ex_rs2_fwd, mem_result;
  logic [3:0]  ALUSel;
  logic        ex_valid, ex_reg_wen, ex_is_load;
  logic [4:0]  ex_rd, mem_rd;
  logic        mem_valid, mem_reg_wen, mem_is_load, stall_id;

  int checks = 0;
  int errors = 0;

  ex_operand_stage #(.NOP_ALUSEL(NOP)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_alu_sel(id_alu_sel), .id_reg_wen(id_reg_wen), .id_is_load(id_is_load),
    .flush(flush), .alu_out(alu_out), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .wb_data(wb_data), .Data_A(Data_A), .Data_B(Data_B), .ALUSel(ALUSel),
    .ex_rs2_fwd(ex_rs2_fwd), .ex_valid(ex_valid), .ex_reg_wen(ex_reg_wen),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .mem_result(mem_result),
    .mem_rd(mem_rd), .mem_valid(mem_valid), .mem_reg_wen(mem_reg_wen),
    .mem_is_load(mem_is_load), .stall_id(stall_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: one record per in-flight instruction.
  typedef struct {
    bit          valid;
    logic [31:0] pc, imm, rs1_val, rs2_val;
    logic [4:0]  rs1, rs2, rd;
    bit          a_sel, b_sel, reg_wen, is_load;
    logic [3:0]  alu_sel;
  } instr_t;

  typedef struct {
    bit          valid, reg_wen, is_load;
    logic [4:0]  rd;
    logic [31:0] result;
  } memrec_t;

  instr_t  m_ex;
  memrec_t m_mem;

  function automatic instr_t emptyInstr();
    instr_t b;
    b.valid = 0; b.pc = 0; b.imm = 0; b.rs1_val = 0; b.rs2_val = 0;
    b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.a_sel = 0; b.b_sel = 0;
    b.reg_wen = 0; b.is_load = 0; b.alu_sel = NOP;
    return b;
  endfunction

  // Newest available value of architectural register idx as seen in EX.
  function automatic logic [31:0] freshest(logic [4:0] idx, logic [31:0] held);
    if (idx == 0) return held;
    if (m_mem.valid && m_mem.reg_wen && !m_mem.is_load && m_mem.rd == idx) return m_mem.result;
    if (wb_wen && wb_rd == idx) return wb_data;
    return held;
  endfunction

  function automatic bit expStall();
    if (!id_valid || flush) return 0;
    if (!(m_ex.valid && m_ex.is_load && m_ex.reg_wen) || m_ex.rd == 0) return 0;
    return (m_ex.rd == id_rs1) || (m_ex.rd == id_rs2);
  endfunction

  task automatic modelUpdate();
    bit kill;
    instr_t n;
    kill = flush || expStall();
    if (rst) begin
      m_mem = '{default: 0};
      m_ex  = emptyInstr();
    end else begin
      m_mem.valid   = m_ex.valid;
      m_mem.reg_wen = m_ex.reg_wen;
      m_mem.is_load = m_ex.is_load;
      m_mem.rd      = m_ex.rd;
      m_mem.result  = alu_out;
      if (kill) begin
        m_ex = emptyInstr();
      end else begin
        n.valid = id_valid; n.pc = id_pc; n.imm = id_imm;
        n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
        n.a_sel = id_a_sel; n.b_sel = id_b_sel; n.alu_sel = id_alu_sel;
        n.reg_wen = id_reg_wen; n.is_load = id_is_load;
        n.rs1_val = (wb_wen && wb_rd != 0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
        n.rs2_val = (wb_wen && wb_rd != 0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
        m_ex = n;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [31:0] r2;
    r2 = freshest(m_ex.rs2, m_ex.rs2_val);
    checkOutput({tag, ".Data_A"}, Data_A,
                m_ex.a_sel ? m_ex.pc : freshest(m_ex.rs1, m_ex.rs1_val));
    checkOutput({tag, ".Data_B"}, Data_B, m_ex.b_sel ? m_ex.imm : r2);
    checkOutput({tag, ".ex_rs2_fwd"}, ex_rs2_fwd, r2);
    checkOutput({tag, ".ALUSel"}, {28'd0, ALUSel}, {28'd0, m_ex.alu_sel});
    checkOutput({tag, ".ex_flags"}, {29'd0, ex_valid, ex_reg_wen, ex_is_load},
                {29'd0, m_ex.valid, m_ex.reg_wen, m_ex.is_load});
    checkOutput({tag, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, m_ex.rd});
    checkOutput({tag, ".mem_result"}, mem_result, m_mem.result);
    checkOutput({tag, ".mem_flags"}, {24'd0, mem_rd, mem_valid, mem_reg_wen, mem_is_load},
                {24'd0, m_mem.rd, m_mem.valid, m_mem.reg_wen, m_mem.is_load});
    checkOutput({tag, ".stall_id"}, {31'd0, stall_id}, {31'd0, expStall()});
  endtask

  task automatic clearInputs();
    id_valid = 0; id_pc = 0; id_imm = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_a_sel = 0; id_b_sel = 0;
    id_alu_sel = 0; id_reg_wen = 0; id_is_load = 0; flush = 0;
    alu_out = 0; wb_wen = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic applyStimulus(input bit random_rst);
    id_valid = $urandom_range(0, 3) != 0;
    id_pc = $urandom; id_imm = $urandom;
    id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 3));
    id_a_sel = 1'($urandom); id_b_sel = 1'($urandom);
    id_alu_sel = 4'($urandom);
    id_reg_wen = 1'($urandom); id_is_load = $urandom_range(0, 2) == 0;
    flush = $urandom_range(0, 7) == 0;
    alu_out = $urandom;
    wb_wen = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
    rst = random_rst && ($urandom_range(0, 39) == 0);
  endtask

  task automatic setInstr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] rs1_data, input logic [31:0] rs2_data,
                          input bit b_sel, input logic [31:0] imm, input logic [3:0] alu,
                          input bit is_load);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = rs1_data; id_rs2_data = rs2_data; id_b_sel = b_sel;
    id_a_sel = 0; id_imm = imm; id_alu_sel = alu; id_reg_wen = 1;
    id_is_load = is_load; id_pc = 32'h0000_1000;
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    #1;
  endtask

  initial begin
    m_ex  = emptyInstr();
    m_mem = '{default: 0};
    clearInputs();

    // Reset with random ID inputs held for two cycles
    applyStimulus(0);
    rst = 1;
    tick();
    applyStimulus(0);
    rst = 1;
    tick();
    rst = 0;
    clearInputs();
    #1;
    checkOutput("reset.Data_A", Data_A, 32'd0);
    checkOutput("reset.Data_B", Data_B, 32'd0);
    checkOutput("reset.ALUSel", {28'd0, ALUSel}, 32'd0);
    checkOutput("reset.valid", {30'd0, ex_valid, mem_valid}, 32'd0);
    checkOutput("reset.stall", {31'd0, stall_id}, 32'd0);
    checkAll("reset");

    // addi x1,x0,5 then add x2,x1,x1 with stale register-file data
    setInstr(0, 0, 1, 0, 0, 1, 5, 4'b0000, 0);
    tick();
    setInstr(1, 1, 2, 7, 7, 0, 0, 4'b0000, 0);
    alu_out = 5;
    tick();
    clearInputs();
    #1;
    checkOutput("memfwd.Data_A", Data_A, 32'd5);
    checkOutput("memfwd.Data_B", Data_B, 32'd5);
    checkOutput("memfwd.ALUSel", {28'd0, ALUSel}, 32'd0);
    checkAll("memfwd");

    // x1 in WB while the consumer sits in ID: capture bypass
    setInstr(1, 0, 6, 7, 0, 0, 0, 4'b0000, 0);
    wb_wen = 1; wb_rd = 1; wb_data = 9;
    tick();
    clearInputs();
    #1;
    checkOutput("capbypass.Data_A", Data_A, 32'd9);
    checkAll("capbypass");
    tick();
    tick();

    // x1 in WB while the consumer sits in EX
    setInstr(1, 0, 7, 7, 0, 0, 0, 4'b0000, 0);
    tick();
    clearInputs();
    wb_wen = 1; wb_rd = 1; wb_data = 9;
    #1;
    checkOutput("wbfwd.Data_A", Data_A, 32'd9);
    checkAll("wbfwd");
    clearInputs();
    tick();
    tick();

    // Load-use: lw x3 then add x4,x3,x0
    setInstr(0, 0, 3, 0, 0, 1, 0, 4'b0000, 1);
    tick();
    setInstr(3, 0, 4, 32'h11, 0, 0, 0, 4'b0000, 0);
    #1;
    checkOutput("loaduse.stall1", {31'd0, stall_id}, 32'd1);
    checkAll("loaduse.c1");
    tick();
    checkOutput("loaduse.stall2", {31'd0, stall_id}, 32'd0);
    checkOutput("loaduse.bubble", {31'd0, ex_valid}, 32'd0);
    checkAll("loaduse.c2");
    tick();
    clearInputs();
    wb_wen = 1; wb_rd = 3; wb_data = 32'hDEAD_BEEF;
    #1;
    checkOutput("loaduse.Data_A", Data_A, 32'hDEAD_BEEF);
    checkAll("loaduse.c3");
    clearInputs();
    tick();
    tick();

    // Flush during a load-use condition
    setInstr(0, 0, 3, 0, 0, 1, 0, 4'b0000, 1);
    tick();
    setInstr(3, 0, 4, 32'h11, 0, 0, 0, 4'b1000, 0);
    flush = 1;
    #1;
    checkOutput("flush.stall", {31'd0, stall_id}, 32'd0);
    checkAll("flush.c1");
    tick();
    clearInputs();
    #1;
    checkOutput("flush.ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("flush.ALUSel", {28'd0, ALUSel}, 32'd0);
    checkAll("flush.c2");
    tick();

    // Reset while stalled
    setInstr(0, 0, 3, 0, 0, 1, 0, 4'b0000, 1);
    tick();
    setInstr(3, 3, 4, 0, 0, 0, 0, 4'b0000, 0);
    #1;
    checkOutput("rststall.pre", {31'd0, stall_id}, 32'd1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    checkOutput("rststall.stall", {31'd0, stall_id}, 32'd0);
    checkOutput("rststall.valid", {30'd0, ex_valid, mem_valid}, 32'd0);
    checkAll("rststall");
    clearInputs();
    tick();

    // x0: addi x0,x0,3 then add x5,x0,x0, with a WB write aimed at x0
    setInstr(0, 0, 0, 0, 0, 1, 3, 4'b0000, 0);
    tick();
    setInstr(0, 0, 5, 0, 0, 0, 0, 4'b0000, 0);
    alu_out = 3;
    wb_wen = 1; wb_rd = 0; wb_data = 32'h5555_AAAA;
    tick();
    clearInputs();
    wb_wen = 1; wb_rd = 0; wb_data = 32'h5555_AAAA;
    #1;
    checkOutput("x0.Data_A", Data_A, 32'd0);
    checkOutput("x0.Data_B", Data_B, 32'd0);
    checkAll("x0.fwd");
    clearInputs();
    setInstr(0, 0, 0, 0, 0, 1, 0, 4'b0000, 1);
    tick();
    setInstr(0, 0, 6, 0, 0, 0, 0, 4'b0000, 0);
    #1;
    checkOutput("x0.stall", {31'd0, stall_id}, 32'd0);
    checkAll("x0.load");
    clearInputs();
    tick();

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1);
      #1;
      checkAll("random");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
